mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Two-master arbiter between HLS-generated kernel FSMs (memset, memcpy and similar) and the shared memory_controller port.
- Each master issues single-beat read/write requests; the arbiter registers the winning request onto the controller port.
- Tracks outstanding reads through a fixed-latency tag pipeline and steers read data back to the master that issued the read.
- Round-robin fairness; throughput of one request per cycle.

Parameters:
- ADDR_W, 32, address width (matches MEMORY_CONTROLLER_ADDR_SIZE)
- DATA_W, 32, data width (matches MEMORY_CONTROLLER_DATA_SIZE)
- RD_LATENCY, 1, cycles from mc_* presented to mc_out valid; legal range 1..4

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- m0_req  in  1  master 0 request valid
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_gnt  out  1  master 0 request accepted this cycle
- m0_rvalid  out  1  master 0 read data valid
- m0_rdata  out  DATA_W  master 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as master 0, for master 1
- mc_address  out  ADDR_W  to memory_controller_address
- mc_write_enable  out  1  to memory_controller_write_enable
- mc_in  out  DATA_W  to memory_controller_in
- mc_out  in  DATA_W  from memory_controller_out

Behaviour:
- Reset and clock: reset is synchronous and active-high; clock is clk.
- Reset values:
  - mc_address = 0, mc_write_enable = 0, mc_in = 0.
  - Tag pipeline cleared; all rvalid = 0.
  - Round-robin pointer last = 1, so master 0 wins the first contention.
- Grant (combinational, same cycle as req):
  - Only m0_req high: m0_gnt = 1.
  - Only m1_req high: m1_gnt = 1.
  - Both high: grant the master != last.
  - At most one gnt is high per cycle. gnt is never high while reset is high.
- Master contract:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - The cycle after gnt, present the next request or drop req.
- Issue stage:
  - When a gnt fires at cycle t, the selected addr, we and wdata are registered onto mc_* and are valid at t+1.
  - last <= granted id.
  - With no grant at t: mc_write_enable = 0 at t+1; mc_address and mc_in hold their previous values.
  - A write is a single cycle on mc_write_enable; there is no write response.
- Read return:
  - Each granted read pushes {valid = 1, id} into a RD_LATENCY+1 deep shift register; writes and idle cycles push valid = 0.
  - A read granted at t gives m<id>_rvalid = 1 at t+1+RD_LATENCY, with m<id>_rdata = mc_out (combinational pass-through).
  - The non-owning master sees rvalid = 0.
  - rdata of both masters is driven from mc_out at all times; it is meaningful only while rvalid is high.
- Back-to-back:
  - Alternating reads from m0 and m1 return in issue order, one per cycle, with no bubbles.
  - Read-after-write to the same address by the same master returns the new data; ordering is preserved because there is a single issue path.
- Reset mid-operation: in-flight reads are discarded and no rvalid follows reset. Masters must re-issue.
- Width rules: no address translation; full ADDR_W is passed through.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Enabled:
  - Adds ports m0_lock and m1_lock (in, 1 each).
  - While the last-granted master holds lock = 1 together with req = 1, it wins every cycle and the other master is starved. This is used for burst fills.
  - When lock drops or req drops, normal round-robin resumes, with last = the locking master.
- Disabled: the ports are absent and the block is pure round-robin.

Decomposition:
- Shared package mem_arb_pkg holds:
  - ADDR_W and DATA_W defaults
  - master-id typedef (1 bit)
  - tag-entry struct {valid, id}
- Natural sub-module: mem_arb_rd_tag_pipe, the parameterised RD_LATENCY+1 shift register of tag entries with synchronous clear.

Test Plan:
- Reset, then m0 writes addr 0x10 data 0xA5 -> m0_gnt at t; mc_write_enable = 1, mc_address = 0x10, mc_in = 0xA5 at t+1; mc_write_enable = 0 at t+2.
- m0 and m1 both read continuously, RD_LATENCY = 1 -> grants alternate m0, m1, m0, m1; each rvalid appears 2 cycles after its gnt, only on the owner; memory model data matches address.
- m1 alone issues 4 back-to-back reads of addr 0..3 -> m1_gnt high for 4 cycles; m1_rvalid high for 4 consecutive cycles with data 0..3 in order; m0_rvalid stays 0.
- Reset asserted one cycle after an m0 read is granted -> no m0_rvalid ever appears; mc_write_enable = 0 and outputs are at reset values the cycle after reset.
- Both request with m0 as last granted -> m1_gnt = 1 first.
- With MEM_ARB_LOCK_EN: m0 holds lock for 5 writes while m1 requests -> m1 gets no gnt for 5 cycles, then is granted on the first cycle after lock drops.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory request arbiter: default widths,
// master identifier and the read-tag entry carried through the return pipeline.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef logic master_id_t;

   typedef struct packed {
      logic       valid;
      master_id_t id;
   } tag_entry_t;

   localparam tag_entry_t TAG_IDLE = '{valid: 1'b0, id: 1'b0};

endpackage

// File: rtl/mem_arb_rd_tag_pipe.sv
// Fixed-depth shift register of read tags; the tail entry lines up with the
// cycle on which the memory controller's read data is valid.
module mem_arb_rd_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  tag_entry_t push,
   output tag_entry_t tail
);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      tag_entry_t entry_reg;
      tag_entry_t entry_in;

      if (gi == 0) begin : g_head
         assign entry_in = push;
      end else begin : g_body
         assign entry_in = g_stage[gi-1].entry_reg;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            entry_reg <= TAG_IDLE;
         end else begin
            entry_reg <= entry_in;
         end
      end
   end

   assign tail = g_stage[DEPTH-1].entry_reg;

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-master round-robin arbiter onto a single memory_controller port with
// read-data steering. Define MEM_ARB_LOCK_EN to add per-master lock inputs.
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
`ifdef MEM_ARB_LOCK_EN
   input  logic              m0_lock,
`endif
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
`ifdef MEM_ARB_LOCK_EN
   input  logic              m1_lock,
`endif
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,

   output logic [ADDR_W-1:0] mc_address,
   output logic              mc_write_enable,
   output logic [DATA_W-1:0] mc_in,
   input  logic [DATA_W-1:0] mc_out
);

   localparam int TAG_DEPTH = RD_LATENCY + 1;

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              lock_hold;
   master_id_t        last_reg;
   master_id_t        win_id;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [ADDR_W-1:0] mc_address_reg;
   logic              mc_write_enable_reg;
   logic [DATA_W-1:0] mc_in_reg;
   tag_entry_t        push_tag;
   tag_entry_t        tail_tag;

   assign req = {m1_req, m0_req};

   // A lock only matters when its owner was the last master granted.
`ifdef MEM_ARB_LOCK_EN
   assign lock_hold = last_reg ? (m1_req & m1_lock) : (m0_req & m0_lock);
`else
   assign lock_hold = 1'b0;
`endif

   always_comb begin
      gnt    = 2'b00;
      win_id = last_reg;
      case (req)
         2'b01:   win_id = 1'b0;
         2'b10:   win_id = 1'b1;
         2'b11:   win_id = lock_hold ? last_reg : ~last_reg;
         default: win_id = last_reg;
      endcase
      if (!reset && (req != 2'b00)) begin
         gnt[win_id] = 1'b1;
      end
   end

   assign m0_gnt = gnt[0];
   assign m1_gnt = gnt[1];

   assign sel_we    = win_id ? m1_we    : m0_we;
   assign sel_addr  = win_id ? m1_addr  : m0_addr;
   assign sel_wdata = win_id ? m1_wdata : m0_wdata;

   // Address and write data hold when idle; only the write strobe returns low.
   always_ff @(posedge clk) begin
      if (reset) begin
         mc_address_reg      <= '0;
         mc_write_enable_reg <= 1'b0;
         mc_in_reg           <= '0;
         last_reg            <= 1'b1;
      end else begin
         mc_write_enable_reg <= (|gnt) & sel_we;
         if (|gnt) begin
            mc_address_reg <= sel_addr;
            mc_in_reg      <= sel_wdata;
            last_reg       <= win_id;
         end
      end
   end

   assign mc_address      = mc_address_reg;
   assign mc_write_enable = mc_write_enable_reg;
   assign mc_in           = mc_in_reg;

   assign push_tag = '{valid: (|gnt) & ~sel_we, id: win_id};

   mem_arb_rd_tag_pipe #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_pipe (
      .clk   (clk),
      .reset (reset),
      .push  (push_tag),
      .tail  (tail_tag)
   );

   assign m0_rvalid = ~reset & tail_tag.valid & (tail_tag.id == 1'b0);
   assign m1_rvalid = ~reset & tail_tag.valid & (tail_tag.id == 1'b1);

   assign m0_rdata = mc_out;
   assign m1_rdata = mc_out;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model of grants, issue and read returns.
module tb_mem_req_arbiter;

   localparam int RD_LAT = 1;
   localparam int AW     = 32;
   localparam int DW     = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    req_s;
   logic [1:0]    we_s;
   logic [AW-1:0] addr_s  [2];
   logic [DW-1:0] wdata_s [2];
`ifdef MEM_ARB_LOCK_EN
   logic [1:0]    lock_s;
`endif
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [AW-1:0] mc_address;
   logic          mc_write_enable;
   logic [DW-1:0] mc_in, mc_out;

   always #5 clk = ~clk;

   mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RD_LAT)) dut (
      .clk             (clk),
      .reset           (reset),
      .m0_req          (req_s[0]),
      .m0_we           (we_s[0]),
      .m0_addr         (addr_s[0]),
      .m0_wdata        (wdata_s[0]),
`ifdef MEM_ARB_LOCK_EN
      .m0_lock         (lock_s[0]),
`endif
      .m0_gnt          (m0_gnt),
      .m0_rvalid       (m0_rvalid),
      .m0_rdata        (m0_rdata),
      .m1_req          (req_s[1]),
      .m1_we           (we_s[1]),
      .m1_addr         (addr_s[1]),
      .m1_wdata        (wdata_s[1]),
`ifdef MEM_ARB_LOCK_EN
      .m1_lock         (lock_s[1]),
`endif
      .m1_gnt          (m1_gnt),
      .m1_rvalid       (m1_rvalid),
      .m1_rdata        (m1_rdata),
      .mc_address      (mc_address),
      .mc_write_enable (mc_write_enable),
      .mc_in           (mc_in),
      .mc_out          (mc_out)
   );

   // Memory controller environment: word i initially holds i, reads take RD_LAT cycles.
   logic [DW-1:0] env_mem [256];
   logic [DW-1:0] rd_line [RD_LAT];
   bit            env_ready;

   assign mc_out = rd_line[RD_LAT-1];

   always @(posedge clk) begin
      if (!env_ready) begin
         for (int i = 0; i < 256; i++) env_mem[i] <= 32'(i);
         env_ready <= 1'b1;
      end else begin
         rd_line[0] <= env_mem[mc_address[7:0]];
         for (int i = 1; i < RD_LAT; i++) rd_line[i] <= rd_line[i-1];
         if (mc_write_enable) env_mem[mc_address[7:0]] <= mc_in;
      end
   end

   // Reference model: arbitration rule, issued-port contents and expected read returns.
   typedef struct {
      int            due;
      logic          id;
      logic [DW-1:0] data;
   } ret_t;

   ret_t          ret_q [$];
   logic [DW-1:0] mdl_mem [256];
   logic          mdl_last;
   logic [AW-1:0] exp_mc_addr;
   logic [DW-1:0] exp_mc_in;
   logic          exp_mc_we;
   int            cyc;
   int            n_cmp;
   int            n_bad;

   function automatic logic [1:0] exp_grant();
      logic hold;
      hold = 1'b0;
`ifdef MEM_ARB_LOCK_EN
      hold = lock_s[mdl_last] && req_s[mdl_last];
`endif
      if (reset || req_s == 2'b00) return 2'b00;
      if (req_s != 2'b11) return req_s;
      if (hold) return mdl_last ? 2'b10 : 2'b01;
      return mdl_last ? 2'b01 : 2'b10;
   endfunction

   task automatic mdl_edge();
      logic [1:0] g;
      int         w;
      ret_t       r;
      g = exp_grant();
      if (reset) begin
         mdl_last    = 1'b1;
         exp_mc_addr = '0;
         exp_mc_in   = '0;
         exp_mc_we   = 1'b0;
         ret_q.delete();
      end else if (g != 2'b00) begin
         w           = g[1] ? 1 : 0;
         exp_mc_addr = addr_s[w];
         exp_mc_in   = wdata_s[w];
         exp_mc_we   = we_s[w];
         mdl_last    = g[1];
         if (we_s[w]) begin
            mdl_mem[addr_s[w][7:0]] = wdata_s[w];
         end else begin
            r.due  = cyc + 1 + RD_LAT;
            r.id   = g[1];
            r.data = mdl_mem[addr_s[w][7:0]];
            ret_q.push_back(r);
         end
      end else begin
         exp_mc_we = 1'b0;
      end
   endtask

   task automatic step();
      mdl_edge();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic flush();
      req_s = 2'b00;
      repeat (RD_LAT + 2) step();
      ret_q.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_s = 2'b11;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if ({m1_gnt, m0_gnt} !== 2'b00) begin
            n_bad++; $display("FAIL rst_gnt: got %b want 00", {m1_gnt, m0_gnt});
         end
         step();
      end
      reset = 1'b0;
      req_s = 2'b00;
      @(negedge clk);
      n_cmp++;
      if (mc_address !== '0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", mc_address); end
      n_cmp++;
      if (mc_write_enable !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", mc_write_enable); end
      n_cmp++;
      if (mc_in !== '0) begin n_bad++; $display("FAIL rst_in: got %h want 0", mc_in); end
      n_cmp++;
      if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
         n_bad++; $display("FAIL rst_rvalid: got %b want 00", {m1_rvalid, m0_rvalid});
      end
      step();
   endtask

   task automatic test_write();
      req_s = 2'b01; we_s[0] = 1'b1; addr_s[0] = 32'h10; wdata_s[0] = 32'hA5;
      @(negedge clk);
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== 2'b01) begin n_bad++; $display("FAIL wr_gnt: got %b want 01", {m1_gnt, m0_gnt}); end
      step();
      req_s = 2'b00;
      @(negedge clk);
      n_cmp++;
      if (mc_write_enable !== 1'b1) begin n_bad++; $display("FAIL wr_we: got %b want 1", mc_write_enable); end
      n_cmp++;
      if (mc_address !== 32'h10) begin n_bad++; $display("FAIL wr_addr: got %h want 10", mc_address); end
      n_cmp++;
      if (mc_in !== 32'hA5) begin n_bad++; $display("FAIL wr_data: got %h want a5", mc_in); end
      step();
      @(negedge clk);
      n_cmp++;
      if (mc_write_enable !== 1'b0) begin n_bad++; $display("FAIL wr_we_drop: got %b want 0", mc_write_enable); end
      n_cmp++;
      if (mc_address !== 32'h10) begin n_bad++; $display("FAIL wr_addr_hold: got %h want 10", mc_address); end
      step();
   endtask

   task automatic test_priority();
      int            t0;
      logic [1:0]    exp_rv;
      logic [DW-1:0] rd;
      req_s = 2'b11; we_s = 2'b00; addr_s[0] = 32'h5; addr_s[1] = 32'h6;
      @(negedge clk);
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== 2'b10) begin n_bad++; $display("FAIL prio_first: got %b want 10", {m1_gnt, m0_gnt}); end
      t0 = cyc;
      step();
      req_s = 2'b01;
      @(negedge clk);
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== 2'b01) begin n_bad++; $display("FAIL prio_second: got %b want 01", {m1_gnt, m0_gnt}); end
      step();
      req_s = 2'b00;
      while (cyc <= t0 + 2 + RD_LAT) begin
         @(negedge clk);
         exp_rv = (cyc == t0 + 1 + RD_LAT) ? 2'b10 : (cyc == t0 + 2 + RD_LAT) ? 2'b01 : 2'b00;
         n_cmp++;
         if ({m1_rvalid, m0_rvalid} !== exp_rv) begin
            n_bad++; $display("FAIL prio_rvalid: cyc %0d got %b want %b", cyc, {m1_rvalid, m0_rvalid}, exp_rv);
         end
         if (exp_rv != 2'b00) begin
            rd = exp_rv[1] ? m1_rdata : m0_rdata;
            n_cmp++;
            if (rd !== (exp_rv[1] ? 32'h6 : 32'h5)) begin
               n_bad++; $display("FAIL prio_rdata: got %h want %h", rd, exp_rv[1] ? 32'h6 : 32'h5);
            end
         end
         step();
      end
      ret_q.delete();
   endtask

   task automatic test_back_to_back();
      int         j;
      logic [1:0] exp_rv;
      for (int k = 0; k < 6 + RD_LAT; k++) begin
         if (k < 4) begin
            req_s = 2'b10; we_s[1] = 1'b0; addr_s[1] = 32'(k);
         end else begin
            req_s = 2'b00;
         end
         @(negedge clk);
         if (k < 4) begin
            n_cmp++;
            if ({m1_gnt, m0_gnt} !== 2'b10) begin
               n_bad++; $display("FAIL b2b_gnt: beat %0d got %b want 10", k, {m1_gnt, m0_gnt});
            end
         end
         j      = k - (1 + RD_LAT);
         exp_rv = (j >= 0 && j < 4) ? 2'b10 : 2'b00;
         n_cmp++;
         if ({m1_rvalid, m0_rvalid} !== exp_rv) begin
            n_bad++; $display("FAIL b2b_rvalid: step %0d got %b want %b", k, {m1_rvalid, m0_rvalid}, exp_rv);
         end
         if (exp_rv != 2'b00) begin
            n_cmp++;
            if (m1_rdata !== 32'(j)) begin n_bad++; $display("FAIL b2b_rdata: got %h want %h", m1_rdata, 32'(j)); end
         end
         step();
      end
      ret_q.delete();
   endtask

   task automatic test_alternating_reads();
      logic [1:0]    eg, exp_rv;
      logic [DW-1:0] exp_rd, rd;
      req_s = 2'b11; we_s = 2'b00; addr_s[0] = $urandom(); addr_s[1] = $urandom();
      for (int k = 0; k < 10 + RD_LAT; k++) begin
         @(negedge clk);
         eg = exp_grant();
         n_cmp++;
         if ({m1_gnt, m0_gnt} !== eg) begin
            n_bad++; $display("FAIL alt_gnt: cyc %0d got %b want %b", cyc, {m1_gnt, m0_gnt}, eg);
         end
         exp_rv = 2'b00;
         exp_rd = '0;
         if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            exp_rv[ret_q[0].id] = 1'b1;
            exp_rd = ret_q[0].data;
            void'(ret_q.pop_front());
         end
         n_cmp++;
         if ({m1_rvalid, m0_rvalid} !== exp_rv) begin
            n_bad++; $display("FAIL alt_rvalid: cyc %0d got %b want %b", cyc, {m1_rvalid, m0_rvalid}, exp_rv);
         end
         if (exp_rv != 2'b00) begin
            rd = exp_rv[1] ? m1_rdata : m0_rdata;
            n_cmp++;
            if (rd !== exp_rd) begin n_bad++; $display("FAIL alt_rdata: cyc %0d got %h want %h", cyc, rd, exp_rd); end
         end
         step();
         if (k + 1 < 8) begin
            if (eg[0]) addr_s[0] = $urandom();
            if (eg[1]) addr_s[1] = $urandom();
         end else begin
            req_s = 2'b00;
         end
      end
      ret_q.delete();
   endtask

   task automatic test_reset_mid();
      req_s = 2'b01; we_s[0] = 1'b0; addr_s[0] = 32'h20; wdata_s[0] = 32'h5A5A_5A5A;
      @(negedge clk);
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== 2'b01) begin n_bad++; $display("FAIL rm_gnt: got %b want 01", {m1_gnt, m0_gnt}); end
      step();
      req_s = 2'b00;
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (mc_write_enable !== 1'b0) begin n_bad++; $display("FAIL rm_we: got %b want 0", mc_write_enable); end
      n_cmp++;
      if (mc_address !== '0) begin n_bad++; $display("FAIL rm_addr: got %h want 0", mc_address); end
      n_cmp++;
      if (mc_in !== '0) begin n_bad++; $display("FAIL rm_in: got %h want 0", mc_in); end
      for (int k = 0; k < RD_LAT + 3; k++) begin
         if (k > 0) @(negedge clk);
         n_cmp++;
         if ({m1_rvalid, m0_rvalid} !== 2'b00) begin
            n_bad++; $display("FAIL rm_rvalid: cyc %0d got %b want 00", cyc, {m1_rvalid, m0_rvalid});
         end
         step();
      end
   endtask

`ifdef MEM_ARB_LOCK_EN
   task automatic test_lock();
      req_s = 2'b01; we_s = 2'b11; lock_s = 2'b00;
      addr_s[0] = 32'h40; wdata_s[0] = 32'h1000; addr_s[1] = 32'h50; wdata_s[1] = 32'h2000;
      @(negedge clk);
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== 2'b01) begin n_bad++; $display("FAIL lock_pre: got %b want 01", {m1_gnt, m0_gnt}); end
      step();
      for (int k = 0; k < 5; k++) begin
         req_s = 2'b11; lock_s = 2'b01; addr_s[0] = 32'h41 + 32'(k); wdata_s[0] = 32'h1001 + 32'(k);
         @(negedge clk);
         n_cmp++;
         if ({m1_gnt, m0_gnt} !== 2'b01) begin
            n_bad++; $display("FAIL lock_hold: beat %0d got %b want 01", k, {m1_gnt, m0_gnt});
         end
         step();
      end
      lock_s = 2'b00;
      @(negedge clk);
      n_cmp++;
      if ({m1_gnt, m0_gnt} !== 2'b10) begin n_bad++; $display("FAIL lock_release: got %b want 10", {m1_gnt, m0_gnt}); end
      step();
      flush();
   endtask
`endif

   task automatic test_random();
      logic [1:0]    eg, exp_rv;
      logic [DW-1:0] exp_rd, rd;
      req_s = 2'b00;
      for (int k = 0; k < 400 + RD_LAT + 2; k++) begin
         @(negedge clk);
         eg = exp_grant();
         n_cmp++;
         if ({m1_gnt, m0_gnt} !== eg) begin
            n_bad++; $display("FAIL rnd_gnt: cyc %0d got %b want %b", cyc, {m1_gnt, m0_gnt}, eg);
         end
         n_cmp++;
         if ({mc_write_enable, mc_address, mc_in} !== {exp_mc_we, exp_mc_addr, exp_mc_in}) begin
            n_bad++; $display("FAIL rnd_issue: cyc %0d got we=%b a=%h d=%h want we=%b a=%h d=%h", cyc,
                              mc_write_enable, mc_address, mc_in, exp_mc_we, exp_mc_addr, exp_mc_in);
         end
         exp_rv = 2'b00;
         exp_rd = '0;
         if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            exp_rv[ret_q[0].id] = 1'b1;
            exp_rd = ret_q[0].data;
            void'(ret_q.pop_front());
         end
         n_cmp++;
         if ({m1_rvalid, m0_rvalid} !== exp_rv) begin
            n_bad++; $display("FAIL rnd_rvalid: cyc %0d got %b want %b", cyc, {m1_rvalid, m0_rvalid}, exp_rv);
         end
         if (exp_rv != 2'b00) begin
            rd = exp_rv[1] ? m1_rdata : m0_rdata;
            n_cmp++;
            if (rd !== exp_rd) begin n_bad++; $display("FAIL rnd_rdata: cyc %0d got %h want %h", cyc, rd, exp_rd); end
         end
         step();
         for (int m = 0; m < 2; m++) begin
            if (k >= 400) begin
               req_s[m] = 1'b0;
            end else if (req_s[m] && !eg[m]) begin
               req_s[m] = 1'b1;
            end else if ($urandom_range(0, 3) != 0) begin
               req_s[m]   = 1'b1;
               we_s[m]    = 1'($urandom_range(0, 1));
               addr_s[m]  = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
               wdata_s[m] = $urandom();
`ifdef MEM_ARB_LOCK_EN
               lock_s[m]  = ($urandom_range(0, 5) == 0);
`endif
            end else begin
               req_s[m] = 1'b0;
            end
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      cyc   = 0;
      for (int i = 0; i < 256; i++) mdl_mem[i] = 32'(i);
      reset      = 1'b1;
      req_s      = 2'b00;
      we_s       = 2'b00;
      addr_s[0]  = '0;
      addr_s[1]  = '0;
      wdata_s[0] = '0;
      wdata_s[1] = '0;
`ifdef MEM_ARB_LOCK_EN
      lock_s     = 2'b00;
`endif
      test_reset();
      test_write();
      test_priority();
      test_back_to_back();
      test_alternating_reads();
      test_reset_mid();
`ifdef MEM_ARB_LOCK_EN
      test_lock();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
